axi4_lite_mst_bridge: RTL

//  Parametrised user-to-AXI4-Lite master bridge. Replaces the fixed 32-bit wr/rd controller pair.

---
 rtl/axi4l_pkg.sv | 16 +
 rtl/axi4l_rd_path.sv | 79 +++++++
 rtl/axi4_lite_mst_bridge.sv | 123 ++++++++++++
 3 files changed

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions for the user-to-AXI4-Lite master bridge:
// response codes, fixed protection value and the per-channel FSM encodings.
package axi4l_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // awprot/arprot are not exposed; every access is unprivileged, secure, data.
    localparam logic [2:0] AXI_PROT = 3'b000;

    typedef enum logic [1:0] {WR_IDLE, WR_ISSUE, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;

endpackage

// File: rtl/axi4l_rd_path.sv
// Read channel of the AXI4-Lite master bridge: one outstanding AR/R transaction,
// misaligned requests answered locally with DECERR and rd_data left untouched.
module axi4l_rd_path
    import axi4l_pkg::*;
#(
    parameter int  ADDR_W  = 32,
    parameter int  DATA_W  = 32,
    localparam int ALIGN_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    output logic              rd_ready,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        rd_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    rd_state_t state;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= RD_IDLE;
            rd_ready <= 1'b0;
            rd_done  <= 1'b0;
            rd_data  <= '0;
            rd_err   <= RESP_OKAY;
            araddr   <= '0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            case (state)
                RD_IDLE: begin
                    rd_ready <= 1'b1;
                    if (rd_valid && rd_ready) begin
                        if (rd_addr[ALIGN_W-1:0] != '0) begin
                            rd_done <= 1'b1;
                            rd_err  <= RESP_DECERR;
                        end else begin
                            araddr   <= rd_addr;
                            arvalid  <= 1'b1;
                            rd_ready <= 1'b0;
                            state    <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    // rready is held high for the whole state, so rvalid alone marks the beat.
                    if (rvalid) begin
                        rready   <= 1'b0;
                        rd_data  <= rdata;
                        rd_err   <= rresp;
                        rd_done  <= 1'b1;
                        rd_ready <= 1'b1;
                        state    <= RD_IDLE;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi4_lite_mst_bridge.sv
// User request/response to AXI4-Lite master bridge. Write FSM lives here;
// the read FSM is the axi4l_rd_path instance. The two channels never interact.
module axi4_lite_mst_bridge
    import axi4l_pkg::*;
#(
    parameter int  ADDR_W  = 32,
    parameter int  DATA_W  = 32,
    localparam int STRB_W  = DATA_W / 8,
    localparam int ALIGN_W = $clog2(STRB_W)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              wr_done,
    output logic [1:0]        wr_err,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    output logic              rd_ready,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        rd_err,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [STRB_W-1:0] m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    wr_state_t wr_state;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_state      <= WR_IDLE;
            wr_ready      <= 1'b0;
            wr_done       <= 1'b0;
            wr_err        <= RESP_OKAY;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (wr_state)
                WR_IDLE: begin
                    wr_ready <= 1'b1;
                    if (wr_valid && wr_ready) begin
                        if (wr_addr[ALIGN_W-1:0] != '0) begin
                            wr_done <= 1'b1;
                            wr_err  <= RESP_DECERR;
                        end else begin
                            m_axi_awaddr  <= wr_addr;
                            m_axi_wdata   <= wr_data;
                            m_axi_wstrb   <= wr_strb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            wr_ready      <= 1'b0;
                            wr_state      <= WR_ISSUE;
                        end
                    end
                end
                WR_ISSUE: begin
                    // AW and W retire independently; a low valid means that half already handshook.
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        wr_state     <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        wr_done      <= 1'b1;
                        wr_err       <= m_axi_bresp;
                        wr_ready     <= 1'b1;
                        wr_state     <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    axi4l_rd_path #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_path (
        .clk      (clk),
        .arst_n   (arst_n),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_done  (rd_done),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .araddr   (m_axi_araddr),
        .arvalid  (m_axi_arvalid),
        .arready  (m_axi_arready),
        .rdata    (m_axi_rdata),
        .rresp    (m_axi_rresp),
        .rvalid   (m_axi_rvalid),
        .rready   (m_axi_rready)
    );

endmodule
